pueo_cmd_decoder_pkt: RTL and testbench

Parametrised successor command decoder for the SURF SYSCLK command stream. It decodes 32-bit command words into:
- run-control pulses (sync/reset/stop), with stop actually driven
- trigger strobes carrying a full-width trigger time
- a mode1 byte stream buffered in a packet FIFO that honours tready and commits or drops whole packets
- a firmware byte stream buffered in a FIFO that carries the firmware mark inline

It sits between the command deserialiser and the command processor / firmware-upgrade AXI-S consumers.

---
 rtl/pueo_cmd_pkg.sv | 33 +++
 rtl/pueo_cmd_pkt_fifo.sv | 60 ++++++
 rtl/pueo_cmd_decoder_pkt.sv | 174 +++++++++++++++++
 tb/tb_pueo_cmd_decoder_pkt.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/pueo_cmd_pkg.sv
// Shared field positions, enums and special-command codes for the SURF SYSCLK command decoder.
package pueo_cmd_pkg;

    localparam int CMD_MSG_N_BIT = 31;
    localparam int RUNCMD_LSB    = 26;
    localparam int M1TYPE_LSB    = 24;
    localparam int M1DATA_LSB    = 16;
    localparam int TRIG_BIT      = 15;

    localparam logic [7:0] SPECIAL_RESET   = 8'h01;
    localparam logic [7:0] SPECIAL_FW_MARK = 8'h02;

    typedef enum logic [1:0] {
        M1_SPECIAL = 2'b00,
        M1_NORMAL  = 2'b01,
        M1_FW      = 2'b10,
        M1_LAST    = 2'b11
    } m1type_t;

    typedef enum logic [1:0] {
        RUN_NOP   = 2'b00,
        RUN_SYNC  = 2'b01,
        RUN_RESET = 2'b10,
        RUN_STOP  = 2'b11
    } runcmd_t;

    typedef enum logic [1:0] {
        M1_IDLE = 2'b00,
        M1_PKT  = 2'b01,
        M1_DROP = 2'b10
    } m1state_t;

endpackage

// File: rtl/pueo_cmd_pkt_fifo.sv
// First-word-fall-through FIFO with separate committed/tentative write pointers so whole
// packets become visible at once or are rolled back; flush empties everything.
module pueo_cmd_pkt_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         commit,
    input  logic         rollback,
    input  logic         flush,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         rd_valid,
    output logic         full
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    logic [AW:0]  wp_c, wp_t, rd;
    logic [W-1:0] mem [DEPTH];
    logic         rd_fire, wr_ok;

    assign rd_valid = (rd != wp_c);
    assign rd_data  = rd_valid ? mem[rd[AW-1:0]] : '0;
    assign rd_fire  = rd_en && rd_valid;
    // A read in the same cycle frees the slot the write lands in.
    assign full     = ((wp_t - rd) == DEPTH_P) && !rd_fire;
    assign wr_ok    = wr_en && !full && !flush && !rollback;

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wp_t[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp_c <= '0;
            wp_t <= '0;
            rd   <= '0;
        end else if (flush) begin
            rd   <= wp_c;
            wp_t <= wp_c;
        end else begin
            if (rd_fire)
                rd <= rd + 1'b1;
            if (rollback)
                wp_t <= wp_c;
            else if (wr_ok) begin
                wp_t <= wp_t + 1'b1;
                if (commit)
                    wp_c <= wp_t + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pueo_cmd_decoder_pkt.sv
// SURF SYSCLK command decoder: run pulses, trigger strobes, packetised mode1 and firmware streams.
// Define PUEO_CMDDEC_STATS_EN to build the mode1-drop / firmware-overflow counters.
module pueo_cmd_decoder_pkt
    import pueo_cmd_pkg::*;
#(
    parameter int TRIG_W   = 15,
    parameter int M1_DEPTH = 64,
    parameter int FW_DEPTH = 16,
    parameter int CNT_W    = 16
) (
    input  logic              sysclk_i,
    input  logic              sysrst_n_i,
    input  logic [31:0]       command_i,
    input  logic              command_valid_i,
    output logic              rundosync_o,
    output logic              runrst_o,
    output logic              runstop_o,
    output logic [TRIG_W-1:0] trig_time_o,
    output logic              trig_valid_o,
    output logic              cmdproc_rst_o,
    output logic [7:0]        cmdproc_tdata,
    output logic              cmdproc_tvalid,
    output logic              cmdproc_tlast,
    input  logic              cmdproc_tready,
    output logic [7:0]        fw_tdata,
    output logic              fw_tvalid,
    input  logic              fw_tready,
    output logic              fw_mark_o,
    output logic [CNT_W-1:0]  m1_drop_cnt_o,
    output logic [CNT_W-1:0]  fw_ovf_cnt_o
);

    logic     msg, trigger, special;
    runcmd_t  runcmd;
    m1type_t  m1type;
    logic [7:0] m1data;
    logic     unused_cmd_bits;

    assign msg     = !command_i[CMD_MSG_N_BIT] && command_valid_i;
    assign trigger = command_i[TRIG_BIT] && command_valid_i;
    assign runcmd  = runcmd_t'(command_i[RUNCMD_LSB +: 2]);
    assign m1type  = m1type_t'(command_i[M1TYPE_LSB +: 2]);
    assign m1data  = command_i[M1DATA_LSB +: 8];
    assign special = msg && (m1type == M1_SPECIAL);
    assign unused_cmd_bits = ^command_i;

    logic       s1_m1_wr, s1_m1_last, s1_fw_wr;
    logic [7:0] s1_m1_data;
    logic [8:0] s1_fw_data;

    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            rundosync_o   <= 1'b0;
            runrst_o      <= 1'b0;
            runstop_o     <= 1'b0;
            trig_valid_o  <= 1'b0;
            trig_time_o   <= '0;
            cmdproc_rst_o <= 1'b0;
            s1_m1_wr      <= 1'b0;
            s1_m1_last    <= 1'b0;
            s1_m1_data    <= '0;
            s1_fw_wr      <= 1'b0;
            s1_fw_data    <= '0;
        end else begin
            rundosync_o   <= msg && (runcmd == RUN_SYNC);
            runrst_o      <= msg && (runcmd == RUN_RESET);
            runstop_o     <= msg && (runcmd == RUN_STOP);
            trig_valid_o  <= trigger;
            if (trigger)
                trig_time_o <= command_i[TRIG_W-1:0];
            cmdproc_rst_o <= special && (m1data == SPECIAL_RESET);
            s1_m1_wr      <= msg && ((m1type == M1_NORMAL) || (m1type == M1_LAST));
            s1_m1_last    <= (m1type == M1_LAST);
            s1_m1_data    <= m1data;
            s1_fw_wr      <= (msg && (m1type == M1_FW)) || (special && (m1data == SPECIAL_FW_MARK));
            s1_fw_data    <= (m1type == M1_FW) ? {1'b0, m1data} : {1'b1, 8'h00};
        end
    end

    m1state_t   m1_state;
    logic       m1_full, m1_try, m1_wr, m1_commit, m1_rollback, m1_rd_valid;
    logic [8:0] m1_rd_data;

    always_comb begin
        m1_try      = s1_m1_wr && (m1_state != M1_DROP) && !cmdproc_rst_o;
        m1_wr       = m1_try && !m1_full;
        m1_commit   = m1_wr && s1_m1_last;
        m1_rollback = m1_try && m1_full;
    end

    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i)
            m1_state <= M1_IDLE;
        else if (cmdproc_rst_o)
            m1_state <= M1_IDLE;
        else if (s1_m1_wr) begin
            case (m1_state)
                M1_IDLE, M1_PKT:
                    if (s1_m1_last)   m1_state <= M1_IDLE;
                    else if (m1_full) m1_state <= M1_DROP;
                    else              m1_state <= M1_PKT;
                M1_DROP:
                    if (s1_m1_last)   m1_state <= M1_IDLE;
                default:              m1_state <= M1_IDLE;
            endcase
        end
    end

    pueo_cmd_pkt_fifo #(.W(9), .DEPTH(M1_DEPTH)) u_m1_fifo (
        .clk      (sysclk_i),
        .rst_n    (sysrst_n_i),
        .wr_en    (m1_wr),
        .wr_data  ({s1_m1_last, s1_m1_data}),
        .commit   (m1_commit),
        .rollback (m1_rollback),
        .flush    (cmdproc_rst_o),
        .rd_en    (cmdproc_tready),
        .rd_data  (m1_rd_data),
        .rd_valid (m1_rd_valid),
        .full     (m1_full)
    );

    assign cmdproc_tvalid = m1_rd_valid;
    assign cmdproc_tdata  = m1_rd_data[7:0];
    assign cmdproc_tlast  = m1_rd_data[8];

    logic       fw_full, fw_ovf, fw_rd_valid;
    logic [8:0] fw_rd_data;

    assign fw_ovf = s1_fw_wr && fw_full;

    pueo_cmd_pkt_fifo #(.W(9), .DEPTH(FW_DEPTH)) u_fw_fifo (
        .clk      (sysclk_i),
        .rst_n    (sysrst_n_i),
        .wr_en    (s1_fw_wr),
        .wr_data  (s1_fw_data),
        .commit   (1'b1),
        .rollback (1'b0),
        .flush    (1'b0),
        .rd_en    (fw_tready),
        .rd_data  (fw_rd_data),
        .rd_valid (fw_rd_valid),
        .full     (fw_full)
    );

    assign fw_tvalid = fw_rd_valid;
    assign fw_tdata  = fw_rd_data[7:0];
    assign fw_mark_o = fw_rd_data[8];

`ifdef PUEO_CMDDEC_STATS_EN
    logic [CNT_W-1:0] m1_drop_cnt, fw_ovf_cnt;

    always_ff @(posedge sysclk_i or negedge sysrst_n_i) begin
        if (!sysrst_n_i) begin
            m1_drop_cnt <= '0;
            fw_ovf_cnt  <= '0;
        end else begin
            if (m1_rollback && (m1_drop_cnt != '1))
                m1_drop_cnt <= m1_drop_cnt + 1'b1;
            if (fw_ovf && (fw_ovf_cnt != '1))
                fw_ovf_cnt <= fw_ovf_cnt + 1'b1;
        end
    end

    assign m1_drop_cnt_o = m1_drop_cnt;
    assign fw_ovf_cnt_o  = fw_ovf_cnt;
`else
    logic unused_stats;
    assign unused_stats  = fw_ovf;
    assign m1_drop_cnt_o = '0;
    assign fw_ovf_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_pueo_cmd_decoder_pkt.sv
// Directed bench for pueo_cmd_decoder_pkt: run pulses, triggers, mode1 packets, firmware FIFO.
module tb_pueo_cmd_decoder_pkt;

    localparam int TRIG_W = 15;
    localparam int CNT_W  = 16;
`ifdef PUEO_CMDDEC_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic              sysclk_i = 1'b0;
    logic              sysrst_n_i = 1'b0;
    logic [31:0]       command_i = '0;
    logic              command_valid_i = 1'b0;
    logic              rundosync_o, runrst_o, runstop_o;
    logic [TRIG_W-1:0] trig_time_o;
    logic              trig_valid_o, cmdproc_rst_o;
    logic [7:0]        cmdproc_tdata;
    logic              cmdproc_tvalid, cmdproc_tlast;
    logic              cmdproc_tready = 1'b0;
    logic [7:0]        fw_tdata;
    logic              fw_tvalid;
    logic              fw_tready = 1'b0;
    logic              fw_mark_o;
    logic [CNT_W-1:0]  m1_drop_cnt_o, fw_ovf_cnt_o;

    int total = 0;
    int bad   = 0;
    logic seen_valid;

    always #5 sysclk_i = ~sysclk_i;

    pueo_cmd_decoder_pkt dut (
        .sysclk_i        (sysclk_i),
        .sysrst_n_i      (sysrst_n_i),
        .command_i       (command_i),
        .command_valid_i (command_valid_i),
        .rundosync_o     (rundosync_o),
        .runrst_o        (runrst_o),
        .runstop_o       (runstop_o),
        .trig_time_o     (trig_time_o),
        .trig_valid_o    (trig_valid_o),
        .cmdproc_rst_o   (cmdproc_rst_o),
        .cmdproc_tdata   (cmdproc_tdata),
        .cmdproc_tvalid  (cmdproc_tvalid),
        .cmdproc_tlast   (cmdproc_tlast),
        .cmdproc_tready  (cmdproc_tready),
        .fw_tdata        (fw_tdata),
        .fw_tvalid       (fw_tvalid),
        .fw_tready       (fw_tready),
        .fw_mark_o       (fw_mark_o),
        .m1_drop_cnt_o   (m1_drop_cnt_o),
        .fw_ovf_cnt_o    (fw_ovf_cnt_o)
    );

    task automatic tick;
        @(posedge sysclk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one valid word for a single cycle; returns 1 cycle later (stage-1 outputs visible).
    task automatic send(input logic [31:0] w);
        command_i       = w;
        command_valid_i = 1'b1;
        tick();
        command_valid_i = 1'b0;
        command_i       = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick();
        chk("rst_pulses", {rundosync_o, runrst_o, runstop_o, trig_valid_o, cmdproc_rst_o}, 64'h0);
        chk("rst_trig_time", trig_time_o, 64'h0);
        chk("rst_streams", {cmdproc_tvalid, cmdproc_tlast, cmdproc_tdata, fw_tvalid, fw_mark_o, fw_tdata}, 64'h0);
        chk("rst_counters", {m1_drop_cnt_o, fw_ovf_cnt_o}, 64'h0);
        sysrst_n_i = 1'b1;
        tick();

        // run-control pulses
        send(32'h0400_0000);
        chk("sync_pulse", {rundosync_o, runrst_o, runstop_o}, 64'b100);
        send(32'h0800_0000);
        chk("runrst_pulse", {rundosync_o, runrst_o, runstop_o}, 64'b010);
        send(32'h0C00_0000);
        chk("runstop_pulse", {rundosync_o, runrst_o, runstop_o}, 64'b001);
        tick();
        chk("run_idle", {rundosync_o, runrst_o, runstop_o}, 64'b000);

        // trigger with bit 31 set: no message side effects
        send(32'h8000_9ABC);
        chk("trig_valid", trig_valid_o, 64'h1);
        chk("trig_time", trig_time_o, 64'h1ABC);
        chk("trig_no_msg", {rundosync_o, runrst_o, runstop_o, cmdproc_rst_o}, 64'h0);
        tick();
        chk("trig_one_cycle", trig_valid_o, 64'h0);
        chk("trig_no_stream", {cmdproc_tvalid, fw_tvalid}, 64'h0);

        // mode1 three-byte packet
        cmdproc_tready = 1'b1;
        send(32'h0111_0000);
        chk("m1_wait_a", cmdproc_tvalid, 64'h0);
        send(32'h0122_0000);
        chk("m1_wait_b", cmdproc_tvalid, 64'h0);
        send(32'h0333_0000);
        chk("m1_wait_c", cmdproc_tvalid, 64'h0);
        tick();
        chk("m1_b0", {cmdproc_tvalid, cmdproc_tlast, cmdproc_tdata}, {54'h0, 1'b1, 1'b0, 8'h11});
        tick();
        chk("m1_b1", {cmdproc_tvalid, cmdproc_tlast, cmdproc_tdata}, {54'h0, 1'b1, 1'b0, 8'h22});
        tick();
        chk("m1_b2", {cmdproc_tvalid, cmdproc_tlast, cmdproc_tdata}, {54'h0, 1'b1, 1'b1, 8'h33});
        tick();
        chk("m1_empty", cmdproc_tvalid, 64'h0);

        // oversize packet dropped while stalled
        cmdproc_tready = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 65; i++) begin
            send({8'h01, i[7:0], 16'h0000});
            seen_valid = seen_valid | cmdproc_tvalid;
        end
        send(32'h03FF_0000);
        seen_valid = seen_valid | cmdproc_tvalid;
        tick(); tick();
        seen_valid = seen_valid | cmdproc_tvalid;
        chk("ovsz_no_output", seen_valid, 64'h0);
        chk("ovsz_drop_cnt", m1_drop_cnt_o, 64'(STATS));
        cmdproc_tready = 1'b1;
        send(32'h01C1_0000);
        send(32'h03C2_0000);
        tick();
        chk("post_drop_b0", {cmdproc_tvalid, cmdproc_tlast, cmdproc_tdata}, {54'h0, 1'b1, 1'b0, 8'hC1});
        tick();
        chk("post_drop_b1", {cmdproc_tvalid, cmdproc_tlast, cmdproc_tdata}, {54'h0, 1'b1, 1'b1, 8'hC2});
        tick();
        chk("post_drop_empty", cmdproc_tvalid, 64'h0);

        // mode1 reset mid-packet
        send(32'h01AA_0000);
        send(32'h0001_0000);
        chk("m1rst_pulse", cmdproc_rst_o, 64'h1);
        send(32'h03BB_0000);
        chk("m1rst_pulse_end", {cmdproc_rst_o, cmdproc_tvalid}, 64'h0);
        tick();
        chk("m1rst_bb", {cmdproc_tvalid, cmdproc_tlast, cmdproc_tdata}, {54'h0, 1'b1, 1'b1, 8'hBB});
        tick();
        chk("m1rst_empty", cmdproc_tvalid, 64'h0);

        // firmware FIFO overflow and in-order mark
        fw_tready = 1'b0;
        send(32'h025A_0000);
        send(32'h0002_0000);
        for (int i = 0; i < 15; i++)
            send({8'h02, 8'h10 + i[7:0], 16'h0000});
        tick(); tick();
        chk("fw_ovf_cnt", fw_ovf_cnt_o, 64'(STATS));
        chk("fw_head", {fw_tvalid, fw_mark_o, fw_tdata}, {54'h0, 1'b1, 1'b0, 8'h5A});
        tick();
        chk("fw_head_stable", {fw_tvalid, fw_mark_o, fw_tdata}, {54'h0, 1'b1, 1'b0, 8'h5A});
        chk("fw_no_m1", cmdproc_tvalid, 64'h0);
        fw_tready = 1'b1;
        tick();
        chk("fw_mark", {fw_tvalid, fw_mark_o, fw_tdata}, {54'h0, 1'b1, 1'b1, 8'h00});
        for (int i = 0; i < 14; i++) begin
            tick();
            chk("fw_byte", {fw_tvalid, fw_mark_o, fw_tdata}, {54'h0, 1'b1, 1'b0, 8'h10 + i[7:0]});
        end
        tick();
        chk("fw_drained", fw_tvalid, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
